// File: rtl/bus_pkg.sv
// Shared system bus definitions: device slot IDs, bus geometry, arbiter states.
package bus_pkg;

    localparam int BUS_NUM_DEVICES = 8;
    localparam int BUS_D_WIDTH     = 32;
    localparam int BUS_C_WIDTH     = 8;

    localparam int DEV_RAM  = 0;
    localparam int DEV_ROM  = 1;
    localparam int DEV_VGA  = 2;
    localparam int DEV_PS2  = 3;
    localparam int DEV_ACP  = 4;
    localparam int DEV_UART = 6;
    localparam int DEV_CPU  = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set bit of eligible_i scanning last_i+1 upward.
module rr_pick
    import bus_pkg::*;
#(
    parameter int N = BUS_NUM_DEVICES,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] eligible_i,
    input  logic [W-1:0] last_i,
    output logic [W-1:0] pick_o,
    output logic         valid_o
);

    logic [W:0] idx;

    // Scan from lowest priority to highest so the last hit wins.
    always_comb begin
        pick_o  = '0;
        valid_o = |eligible_i;
        idx     = '0;
        for (int i = N; i >= 1; i--) begin
            idx = {1'b0, last_i} + (W+1)'(i);
            if (idx >= (W+1)'(N)) begin
                idx = idx - (W+1)'(N);
            end
            if (eligible_i[idx[W-1:0]]) begin
                pick_o = idx[W-1:0];
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin system bus arbiter with turnaround cycle, grant watchdog
// and owner data/ctrl steering.
module bus_arbiter_rr
    import bus_pkg::*;
#(
    parameter int NUM_DEVICES = BUS_NUM_DEVICES,
    parameter int D_WIDTH     = BUS_D_WIDTH,
    parameter int C_WIDTH     = BUS_C_WIDTH,
    parameter int TIMEOUT     = 1024,
    parameter int OWN_W       = $clog2(NUM_DEVICES)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_DEVICES-1:0]         req,
    output logic [NUM_DEVICES-1:0]         ack,
    input  logic [NUM_DEVICES*D_WIDTH-1:0] bus_in,
    input  logic [NUM_DEVICES*C_WIDTH-1:0] ctrl_in,
    output logic [D_WIDTH-1:0]             bus_out,
    output logic [C_WIDTH-1:0]             ctrl_out,
    output logic [OWN_W-1:0]               owner,
    output logic                           busy,
    output logic                           timeout_pulse
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [OWN_W-1:0] LAST_RST = OWN_W'(NUM_DEVICES - 1);

    arb_state_e             state_q, state_d;
    logic [NUM_DEVICES-1:0] ack_q, ack_d;
    logic [NUM_DEVICES-1:0] mask_q, mask_d;
    logic [OWN_W-1:0]       owner_q, owner_d;
    logic [OWN_W-1:0]       last_q, last_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   tpulse_q, tpulse_d;

    logic [NUM_DEVICES-1:0] eligible;
    logic [OWN_W-1:0]       pick;
    logic                   pick_valid;

    logic [D_WIDTH-1:0] data_slc [NUM_DEVICES];
    logic [C_WIDTH-1:0] ctrl_slc [NUM_DEVICES];

    for (genvar g = 0; g < NUM_DEVICES; g++) begin : g_slc
        assign data_slc[g] = bus_in[g*D_WIDTH +: D_WIDTH];
        assign ctrl_slc[g] = ctrl_in[g*C_WIDTH +: C_WIDTH];
    end

    // A watchdog-revoked device stays out until it drops req once.
    assign eligible = req & ~mask_q;

    rr_pick #(
        .N (NUM_DEVICES),
        .W (OWN_W)
    ) u_pick (
        .eligible_i (eligible),
        .last_i     (last_q),
        .pick_o     (pick),
        .valid_o    (pick_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ack_q    <= '0;
            mask_q   <= '0;
            owner_q  <= '0;
            last_q   <= LAST_RST;
            count_q  <= '0;
            tpulse_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            mask_q   <= mask_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            count_q  <= count_d;
            tpulse_q <= tpulse_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ack_d    = ack_q;
        mask_d   = mask_q & req;
        owner_d  = owner_q;
        last_d   = last_q;
        count_d  = count_q;
        tpulse_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d     = ST_GRANT;
                    owner_d     = pick;
                    ack_d       = '0;
                    ack_d[pick] = 1'b1;
                    count_d     = '0;
                end
            end
            ST_GRANT: begin
                if (!req[owner_q]) begin
                    state_d = ST_TURN;
                    ack_d   = '0;
                    last_d  = owner_q;
                    count_d = '0;
                end else if (count_q == CNT_LAST) begin
                    state_d         = ST_TURN;
                    ack_d           = '0;
                    last_d          = owner_q;
                    count_d         = '0;
                    mask_d[owner_q] = 1'b1;
                    tpulse_d        = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            ST_TURN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                ack_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy     = (state_q == ST_GRANT);
        bus_out  = '0;
        ctrl_out = '0;
        if (busy) begin
            bus_out  = data_slc[owner_q];
            ctrl_out = ctrl_slc[owner_q];
        end
    end

    assign ack           = ack_q;
    assign owner         = owner_q;
    assign timeout_pulse = tpulse_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr: vector table plus multi-cycle sequences.
module tb_bus_arbiter_rr;

    localparam int N  = 8;
    localparam int DW = 32;
    localparam int CW = 8;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N-1:0]    ack;
    logic [N*DW-1:0] bus_in;
    logic [N*CW-1:0] ctrl_in;
    logic [DW-1:0]   bus_out;
    logic [CW-1:0]   ctrl_out;
    logic [2:0]      owner;
    logic            busy;
    logic            timeout_pulse;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit         rst;
        logic [7:0] req;
        logic [7:0] ack;
        logic [2:0] own;
        bit         busy;
        bit         tp;
    } vec_t;

    vec_t vecs[$];

    bus_arbiter_rr #(
        .NUM_DEVICES (N),
        .D_WIDTH     (DW),
        .C_WIDTH     (CW),
        .TIMEOUT     (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .ack           (ack),
        .bus_in        (bus_in),
        .ctrl_in       (ctrl_in),
        .bus_out       (bus_out),
        .ctrl_out      (ctrl_out),
        .owner         (owner),
        .busy          (busy),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dslice(input int i);
        return (i == 0) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(i);
    endfunction

    function automatic logic [7:0] cslice(input int i);
        return 8'hC0 + 8'(i);
    endfunction

    function automatic vec_t mk(input bit r, input logic [7:0] q,
                                input logic [7:0] a, input int o,
                                input bit b, input bit t);
        vec_t v;
        v.rst  = r;
        v.req  = q;
        v.ack  = a;
        v.own  = 3'(o);
        v.busy = b;
        v.tp   = t;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [7:0] eack,
                              input int eown, input bit ebusy, input bit etp);
        chk({tag, ".ack"}, 32'(ack), 32'(eack));
        chk({tag, ".owner"}, 32'(owner), 32'(eown));
        chk({tag, ".busy"}, 32'(busy), 32'(ebusy));
        chk({tag, ".tpulse"}, 32'(timeout_pulse), 32'(etp));
        chk({tag, ".bus_out"}, bus_out, ebusy ? dslice(eown) : 32'h0);
        chk({tag, ".ctrl_out"}, 32'(ctrl_out),
            ebusy ? 32'(cslice(eown)) : 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req   = '0;
        tick();
        expect_out("rst", 8'h00, 0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    // Structural invariants, sampled away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (!$onehot0(ack) || (ack != '0 && !busy)) begin
                errors++;
                $display("FAIL invariant: ack=%0h busy=%0b", ack, busy);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        req   = '0;
        for (int i = 0; i < N; i++) begin
            bus_in[i*DW +: DW]  = dslice(i);
            ctrl_in[i*CW +: CW] = cslice(i);
        end
        #12;

        // Single requester, then 2/7 alternation with 4-cycle tenures.
        vecs.push_back(mk(1, 8'h00, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 8'h01, 8'h01, 0, 1, 0));
        vecs.push_back(mk(0, 8'h01, 8'h01, 0, 1, 0));
        vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0));
        for (int r = 0; r < 2; r++) begin
            vecs.push_back(mk(0, 8'h84, 8'h04, 2, 1, 0));
            vecs.push_back(mk(0, 8'h84, 8'h04, 2, 1, 0));
            vecs.push_back(mk(0, 8'h84, 8'h04, 2, 1, 0));
            vecs.push_back(mk(0, 8'h84, 8'h04, 2, 1, 0));
            vecs.push_back(mk(0, 8'h80, 8'h00, 2, 0, 0));
            vecs.push_back(mk(0, 8'h84, 8'h00, 2, 0, 0));
            vecs.push_back(mk(0, 8'h84, 8'h80, 7, 1, 0));
            vecs.push_back(mk(0, 8'h84, 8'h80, 7, 1, 0));
            vecs.push_back(mk(0, 8'h84, 8'h80, 7, 1, 0));
            vecs.push_back(mk(0, 8'h84, 8'h80, 7, 1, 0));
            vecs.push_back(mk(0, 8'h04, 8'h00, 7, 0, 0));
            vecs.push_back(mk(0, 8'h84, 8'h00, 7, 0, 0));
        end
        // All requesting, one-cycle tenures: order 0..7 then 0.
        vecs.push_back(mk(1, 8'h00, 8'h00, 0, 0, 0));
        for (int k = 0; k <= N; k++) begin
            int d;
            d = k % N;
            vecs.push_back(mk(0, 8'hFF, 8'(1 << d), d, 1, 0));
            vecs.push_back(mk(0, 8'hFF & ~8'(1 << d), 8'h00, d, 0, 0));
            vecs.push_back(mk(0, 8'hFF, 8'h00, d, 0, 0));
        end

        foreach (vecs[i]) begin
            if (vecs[i].rst) begin
                reset = 1'b1;
                req   = vecs[i].req;
                tick();
            end else begin
                reset = 1'b0;
                req   = vecs[i].req;
                tick();
            end
            expect_out($sformatf("vec%0d", i), vecs[i].ack, int'(vecs[i].own),
                       vecs[i].busy, vecs[i].tp);
        end

        // Watchdog revoke, no regrant while masked, regrant after a drop.
        apply_reset();
        req = 8'h80;
        for (int i = 0; i < TO; i++) begin
            tick();
            expect_out($sformatf("to_grant%0d", i), 8'h80, 7, 1'b1, 1'b0);
        end
        tick();
        expect_out("to_revoke", 8'h00, 7, 1'b0, 1'b1);
        tick();
        expect_out("to_idle", 8'h00, 7, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            expect_out($sformatf("to_masked%0d", i), 8'h00, 7, 1'b0, 1'b0);
        end
        req = 8'h00;
        tick();
        expect_out("to_drop", 8'h00, 7, 1'b0, 1'b0);
        req = 8'h80;
        tick();
        expect_out("to_regrant", 8'h80, 7, 1'b1, 1'b0);

        // Asynchronous reset in the middle of device 6's tenure.
        apply_reset();
        req = 8'hC0;
        tick();
        expect_out("ar_grant", 8'h40, 6, 1'b1, 1'b0);
        tick();
        expect_out("ar_hold", 8'h40, 6, 1'b1, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        expect_out("ar_async", 8'h00, 0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        expect_out("ar_first", 8'h40, 6, 1'b1, 1'b0);

        // Release on the final permitted cycle is a normal release.
        apply_reset();
        req = 8'h01;
        for (int i = 0; i < TO; i++) begin
            tick();
            expect_out($sformatf("rl_grant%0d", i), 8'h01, 0, 1'b1, 1'b0);
        end
        req = 8'h00;
        tick();
        expect_out("rl_release", 8'h00, 0, 1'b0, 1'b0);
        tick();
        expect_out("rl_idle", 8'h00, 0, 1'b0, 1'b0);
        req = 8'h01;
        tick();
        expect_out("rl_regrant", 8'h01, 0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
